// File: rtl/stream_mux_if.sv
// Stream bundle for stream_mux: N producer channels, one consumer and the select controls.
// The master side drives the producer inputs and consumer ready; the slave side is the mux.
interface stream_mux_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 8
);
   localparam int unsigned SEL_W = $clog2(CHANNELS);

   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output slot.
// Fixed-select or round-robin arbitration; one cycle latency, full throughput.
module stream_mux #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 8
) (
   input logic        clk,
   input logic        rst_n,
   stream_mux_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(CHANNELS);

   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_chan;
   logic                r_out_valid;
   logic [SEL_W-1:0]    r_ptr;

   logic                w_slot_free;
   logic                w_grant_valid;
   logic [SEL_W-1:0]    w_grant;
   logic [CHANNELS-1:0] w_in_ready;
   logic                w_xfer;

   assign w_slot_free = !r_out_valid || bus.out_ready;

   always_comb begin
      int unsigned idx;
      w_grant_valid = 1'b0;
      w_grant       = '0;
      idx           = 0;
      if (!bus.mode) begin
         if ((32'(bus.sel) < CHANNELS) && bus.in_valid[bus.sel]) begin
            w_grant_valid = 1'b1;
            w_grant       = bus.sel;
         end
      end else begin
         // Search upward from ptr with wrap; first hit wins.
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = (32'(r_ptr) + i) % CHANNELS;
            if (!w_grant_valid && bus.in_valid[idx]) begin
               w_grant_valid = 1'b1;
               w_grant       = SEL_W'(idx);
            end
         end
      end
   end

   // Gated by rst_n so no handshake completes while the slot is held in reset.
   always_comb begin
      w_in_ready = '0;
      if (rst_n && w_slot_free && w_grant_valid) begin
         w_in_ready[w_grant] = 1'b1;
      end
   end

   assign w_xfer = w_slot_free && w_grant_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_data  <= bus.in_data[32'(w_grant)*WIDTH +: WIDTH];
         r_out_chan  <= w_grant;
         r_out_valid <= 1'b1;
         if (bus.mode) begin
            r_ptr <= (32'(w_grant) == CHANNELS - 1) ? '0 : w_grant + 1'b1;
         end
      end else if (w_slot_free) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_chan  = r_out_chan;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: stimulus pushes hand-computed words into a scoreboard,
// an independent monitor pops and compares on every accepted output beat.
module tb_stream_mux;
   logic       clk;
   logic       rst_n;
   logic [7:0] ch [8];
   logic [10:0] exp_q [$];
   int         n_tests;
   int         n_fail;

   stream_mux_if #(.WIDTH(8), .CHANNELS(8)) bus ();

   stream_mux #(.WIDTH(8), .CHANNELS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   for (genvar k = 0; k < 8; k++) begin : g_pack
      assign bus.in_data[k*8 +: 8] = ch[k];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] chan, input logic [7:0] data);
      exp_q.push_back({chan, data});
   endtask

   // Monitor: every beat accepted by the consumer must match the scoreboard head.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("mon_unexpected_beat", {21'd0, bus.out_chan, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("mon_chan", 32'(bus.out_chan), 32'(e[10:8]));
               check("mon_data", 32'(bus.out_data), 32'(e[7:0]));
            end
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int k = 0; k < 8; k++) ch[k] = 8'h20 + 8'(k);
      rst_n         = 1'b1;
      bus.mode      = 1'b1;
      bus.sel       = '0;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'h00);
      check("rst_out_chan", 32'(bus.out_chan), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h00);
      repeat (2) @(posedge clk);

      // Round-robin fairness and wrap from reset: 0..7 then 0.
      for (int k = 0; k < 8; k++) push(3'(k), 8'h20 + 8'(k));
      push(3'd0, 8'h20);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1 check("rr_in_ready", 32'(bus.in_ready), 32'(8'h01 << i));
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.in_valid = '0;

      // Mid-stream asynchronous reset discards a held word.
      @(posedge clk);
      #1;
      bus.mode      = 1'b0;
      bus.sel       = 3'd2;
      ch[2]         = 8'h5C;
      bus.in_valid  = 8'h04;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'h5C);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out_data", 32'(bus.out_data), 32'h00);
      check("arst_out_chan", 32'(bus.out_chan), 32'd0);
      check("arst_in_ready", 32'(bus.in_ready), 32'h00);
      bus.in_valid = '0;
      @(negedge clk) rst_n = 1'b1;

      // Fixed select of channel 3.
      @(posedge clk);
      #1;
      bus.mode      = 1'b0;
      bus.sel       = 3'd3;
      ch[3]         = 8'hA5;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      push(3'd3, 8'hA5);
      #1 check("fix_in_ready", 32'(bus.in_ready), 32'h08);
      @(posedge clk);
      #1;
      check("fix_out_valid", 32'(bus.out_valid), 32'd1);
      check("fix_out_data", 32'(bus.out_data), 32'hA5);
      check("fix_out_chan", 32'(bus.out_chan), 32'd3);

      // Sparse round-robin from ptr 0: grants 1,7,1,7.
      ch[1]        = 8'h31;
      ch[7]        = 8'h37;
      bus.mode     = 1'b1;
      bus.in_valid = 8'h82;
      push(3'd1, 8'h31);
      push(3'd7, 8'h37);
      push(3'd1, 8'h31);
      push(3'd7, 8'h37);
      for (int i = 0; i < 4; i++) begin
         #1 check("sparse_in_ready", 32'(bus.in_ready), (i % 2 == 0) ? 32'h02 : 32'h80);
         @(posedge clk);
         #1;
      end
      bus.in_valid = '0;

      // Backpressure: 0x3E held three cycles, then load without a bubble.
      @(posedge clk);
      #1;
      ch[0]         = 8'h3E;
      bus.mode      = 1'b1;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b0;
      push(3'd0, 8'h3E);
      #1 check("bp_load_in_ready", 32'(bus.in_ready), 32'h01);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 32'(bus.in_ready), 32'h00);
         check("bp_out_data", 32'(bus.out_data), 32'h3E);
         check("bp_out_chan", 32'(bus.out_chan), 32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      #1 check("bp_release_in_ready", 32'(bus.in_ready), 32'h02);
      push(3'd1, 8'h31);
      @(posedge clk);
      #1;
      check("bp_nobubble_valid", 32'(bus.out_valid), 32'd1);
      check("bp_nobubble_data", 32'(bus.out_data), 32'h31);
      check("bp_nobubble_chan", 32'(bus.out_chan), 32'd1);

      // Fixed select on an idle channel.
      bus.mode     = 1'b0;
      bus.sel      = 3'd5;
      bus.in_valid = 8'hDF;
      #1 check("idle_in_ready", 32'(bus.in_ready), 32'h00);
      @(posedge clk);
      #1;
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      ch[5]        = 8'h11;
      bus.in_valid = 8'hFF;
      push(3'd5, 8'h11);
      #1 check("idle_wake_in_ready", 32'(bus.in_ready), 32'h20);
      @(posedge clk);
      #1;
      check("idle_wake_valid", 32'(bus.out_valid), 32'd1);
      check("idle_wake_data", 32'(bus.out_data), 32'h11);
      check("idle_wake_chan", 32'(bus.out_chan), 32'd5);
      bus.in_valid = '0;

      repeat (3) @(posedge clk);
      #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel streaming multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the team's 8:1 combinational byte mux in data width and channel count. It adds a round-robin arbitration mode alongside software-directed fixed selection. It sits between multiple producer streams and a single consumer, with one cycle of latency and full throughput.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 8, number of input channels (≥2)
- SEL_W, derived localparam = $clog2(CHANNELS), width of select/channel fields

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- in_data  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (one-hot or zero)
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  consumer ready

## Operation
- Single-entry output register. slot_free = !out_valid || out_ready.
- Grant logic is combinational and evaluated every cycle:
  - Fixed mode: grant = sel if sel < CHANNELS and in_valid[sel], else no grant.
  - Round-robin mode: grant = first k with in_valid[k], searching from ptr upward and wrapping CHANNELS-1 → 0; no grant if in_valid == 0.
- in_ready[k] = slot_free && grant valid && grant == k. At most one bit is set. in_ready depends on in_valid and out_ready.
- Input transfer: in_valid[k] && in_ready[k]. At the next edge, out_data ← channel k word, out_chan ← k, out_valid ← 1.
- If slot_free and there is no grant, out_valid ← 0 at the next edge. out_data and out_chan hold their last values.
- If !slot_free, all registers hold. out_data and out_chan must stay stable while out_valid && !out_ready.
- ptr (SEL_W bits, internal):
  - Round-robin mode: updates only on an input transfer, ptr ← (grant == CHANNELS-1) ? 0 : grant+1.
  - Fixed mode: ptr holds.
- A change on mode or sel takes effect in the same cycle's arbitration. No transfer in flight is affected, because the output register is already loaded.
- Reset (asynchronous, immediate on rst_n low):
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
  - Any held word is discarded.
  - in_ready is 0 while rst_n is low.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle while out_ready stays high. A load and an unload may occur in the same cycle.
- Combinational path out_ready → in_ready exists and is intentional.
- Reset deassertion: the first transfer can occur on the first rising edge with rst_n high.

## Test plan
- Reset: assert rst_n low mid-stream with out_valid=1, out_data=0x5C → out_valid=0, out_data=0x00, out_chan=0 immediately, without waiting for a clock edge. in_ready=0 while rst_n is low.
- Fixed mode: mode=0, sel=3, all in_valid=1, ch3=0xA5, out_ready=1 → in_ready=8'b0000_1000. The next cycle shows out_data=0xA5, out_chan=3, out_valid=1.
- Round-robin fairness and wrap: mode=1, in_valid=8'hFF, out_ready=1 for 9 cycles from reset → out_chan sequence is 0,1,2,3,4,5,6,7,0. Each in_ready bit is asserted exactly once in the first 8 cycles.
- Sparse round-robin: mode=1, ptr=0, in_valid=8'b1000_0010 held → grants alternate 1,7,1,7. ptr takes the values 2, 0, 2, 0.
- Backpressure: out_valid=1, out_data=0x3E, out_ready=0 for 3 cycles with all channels valid:
  - For those 3 cycles, out_data and out_chan are held and in_ready=0.
  - Raising out_ready loads the next granted word at the next edge with no bubble.
- Fixed select on an idle channel: mode=0, sel=5, in_valid[5]=0, other channels valid → no in_ready bit is set. After the held word is consumed, out_valid=0. Raising in_valid[5] with ch5=0x11 gives out_data=0x11, out_chan=5 one cycle later.
